// File: rtl/mreg_pipe_if.sv
// Multiplier-product bus for mreg_pipe: chain enable, product in, and
// registered product / occupancy out.
interface mreg_pipe_if #(
  parameter int WIDTH = 48,
  parameter int OCCW  = 3
);
  logic             CEM;
  logic [WIDTH-1:0] M;
  logic             M_VLD;
  logic [WIDTH-1:0] M_mux;
  logic             M_mux_vld;
  logic             BUSY;
  logic [OCCW-1:0]  OCC;

  modport master (
    output CEM, M, M_VLD,
    input  M_mux, M_mux_vld, BUSY, OCC
  );

  modport slave (
    input  CEM, M, M_VLD,
    output M_mux, M_mux_vld, BUSY, OCC
  );
endinterface

// File: rtl/mreg_pipe.sv
// Configurable 0..4 stage multiplier-output register chain with per-stage valid
// bits and an occupancy counter. Define MREG_PIPE_FLUSH_EN to add the FLUSHM port.
module mreg_pipe #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 1,
  parameter int OCCW  = 3
) (
  input  logic CLK,
  input  logic RSTM,
`ifdef MREG_PIPE_FLUSH_EN
  input  logic FLUSHM,
`endif
  mreg_pipe_if.slave bus
);

  if (DEPTH == 0) begin : gen_bypass
    // No state at all: the product and its qualifier pass straight through.
    logic unused_ctrl;
`ifdef MREG_PIPE_FLUSH_EN
    assign unused_ctrl = ^{CLK, RSTM, bus.CEM, FLUSHM};
`else
    assign unused_ctrl = ^{CLK, RSTM, bus.CEM};
`endif

    assign bus.M_mux     = bus.M;
    assign bus.M_mux_vld = bus.M_VLD;
    assign bus.BUSY      = 1'b0;
    assign bus.OCC       = '0;
  end else begin : gen_pipe
    logic [WIDTH-1:0] q_q [DEPTH];
    logic [WIDTH-1:0] q_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [OCCW-1:0]  occ_q;
    logic [OCCW-1:0]  occ_d;

    always_comb begin
      q_d   = q_q;
      v_d   = v_q;
      occ_d = occ_q;
      if (bus.CEM) begin
        // Data loads every enabled edge; only the valid bit records M_VLD.
        q_d[0] = bus.M;
        v_d[0] = bus.M_VLD;
        for (int k = 1; k < DEPTH; k++) begin
          q_d[k] = q_q[k-1];
          v_d[k] = v_q[k-1];
        end
        occ_d = occ_q + OCCW'(bus.M_VLD) - OCCW'(v_q[DEPTH-1]);
      end
`ifdef MREG_PIPE_FLUSH_EN
      // Flush invalidates the whole chain, drops any incoming product, keeps data.
      if (FLUSHM) begin
        q_d   = q_q;
        v_d   = '0;
        occ_d = '0;
      end
`endif
    end

    always_ff @(posedge CLK or posedge RSTM) begin
      if (RSTM) begin
        q_q   <= '{default: '0};
        v_q   <= '0;
        occ_q <= '0;
      end else begin
        q_q   <= q_d;
        v_q   <= v_d;
        occ_q <= occ_d;
      end
    end

    assign bus.M_mux     = q_q[DEPTH-1];
    assign bus.M_mux_vld = v_q[DEPTH-1];
    assign bus.BUSY      = |v_q;
    assign bus.OCC       = occ_q;
  end

endmodule

// File: tb/tb_mreg_pipe.sv
// Directed scoreboard bench for mreg_pipe at DEPTH 0, 2, 3 and 4; the flush
// scenario is included when MREG_PIPE_FLUSH_EN is defined.
module tb_mreg_pipe;

  logic clk = 1'b0;
  logic rstm = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  mreg_pipe_if #(.WIDTH(48), .OCCW(3)) if0 ();
  mreg_pipe_if #(.WIDTH(48), .OCCW(3)) if2 ();
  mreg_pipe_if #(.WIDTH(48), .OCCW(3)) if3 ();
  mreg_pipe_if #(.WIDTH(48), .OCCW(3)) if4 ();

`ifdef MREG_PIPE_FLUSH_EN
  logic flush0 = 1'b0;
  logic flush2 = 1'b0;
  logic flush3 = 1'b0;
  logic flush4 = 1'b0;
`endif

  mreg_pipe #(.WIDTH(48), .DEPTH(0), .OCCW(3)) u_d0 (
    .CLK(clk), .RSTM(rstm),
`ifdef MREG_PIPE_FLUSH_EN
    .FLUSHM(flush0),
`endif
    .bus(if0.slave));
  mreg_pipe #(.WIDTH(48), .DEPTH(2), .OCCW(3)) u_d2 (
    .CLK(clk), .RSTM(rstm),
`ifdef MREG_PIPE_FLUSH_EN
    .FLUSHM(flush2),
`endif
    .bus(if2.slave));
  mreg_pipe #(.WIDTH(48), .DEPTH(3), .OCCW(3)) u_d3 (
    .CLK(clk), .RSTM(rstm),
`ifdef MREG_PIPE_FLUSH_EN
    .FLUSHM(flush3),
`endif
    .bus(if3.slave));
  mreg_pipe #(.WIDTH(48), .DEPTH(4), .OCCW(3)) u_d4 (
    .CLK(clk), .RSTM(rstm),
`ifdef MREG_PIPE_FLUSH_EN
    .FLUSHM(flush4),
`endif
    .bus(if4.slave));

  logic [47:0] sb2 [$];
  logic [47:0] sb3 [$];
  logic [47:0] sb4 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] exp_d;
    int exp_occ;
    logic exp_vld;

    if0.CEM = 1'b0; if0.M = '0; if0.M_VLD = 1'b0;
    if2.CEM = 1'b0; if2.M = '0; if2.M_VLD = 1'b0;
    if3.CEM = 1'b0; if3.M = '0; if3.M_VLD = 1'b0;
    if4.CEM = 1'b0; if4.M = '0; if4.M_VLD = 1'b0;

    // Reset state
    #12;
    chk("rst_d2_mux", 64'(if2.M_mux), 64'd0);
    chk("rst_d2_vld", 64'(if2.M_mux_vld), 64'd0);
    chk("rst_d2_occ", 64'(if2.OCC), 64'd0);
    chk("rst_d2_busy", 64'(if2.BUSY), 64'd0);
    chk("rst_d3_occ", 64'(if3.OCC), 64'd0);
    chk("rst_d4_busy", 64'(if4.BUSY), 64'd0);
    @(posedge clk);
    #1 rstm = 1'b0;

    // Asynchronous reset mid-stream, DEPTH=2
    if2.CEM = 1'b1; if2.M = 48'h0000_0000_0ABC; if2.M_VLD = 1'b1;
    tick();
    if2.M = 48'h0000_0000_0DEF;
    tick();
    chk("arst_pre_mux", 64'(if2.M_mux), 64'h0ABC);
    chk("arst_pre_occ", 64'(if2.OCC), 64'd2);
    if2.CEM = 1'b0; if2.M_VLD = 1'b0; if2.M = '0;
    #2 rstm = 1'b1;
    #1;
    chk("arst_mux", 64'(if2.M_mux), 64'd0);
    chk("arst_vld", 64'(if2.M_mux_vld), 64'd0);
    chk("arst_occ", 64'(if2.OCC), 64'd0);
    chk("arst_busy", 64'(if2.BUSY), 64'd0);
    #1 rstm = 1'b0;

    // Latency, DEPTH=2
    tick();
    if2.CEM = 1'b1; if2.M = 48'h0000_1234_5678; if2.M_VLD = 1'b1;
    sb2.push_back(48'h0000_1234_5678);
    tick();
    chk("lat_e1_vld", 64'(if2.M_mux_vld), 64'd0);
    chk("lat_e1_occ", 64'(if2.OCC), 64'd1);
    chk("lat_e1_busy", 64'(if2.BUSY), 64'd1);
    if2.M_VLD = 1'b0; if2.M = 48'h0000_0000_5555;
    tick();
    chk("lat_e2_vld", 64'(if2.M_mux_vld), 64'd1);
    chk("lat_e2_occ", 64'(if2.OCC), 64'd1);
    if (sb2.size() > 0) chk("lat_e2_data", 64'(if2.M_mux), 64'(sb2.pop_front()));
    else chk("lat_sb_empty", 64'(sb2.size()), 64'd1);
    tick();
    chk("lat_e3_vld", 64'(if2.M_mux_vld), 64'd0);
    chk("lat_e3_occ", 64'(if2.OCC), 64'd0);
    chk("lat_e3_busy", 64'(if2.BUSY), 64'd0);

    // Stall, DEPTH=3: A,B then 4 stalled cycles, then C
    if3.CEM = 1'b1; if3.M = 48'd1; if3.M_VLD = 1'b1; sb3.push_back(48'd1);
    tick();
    if3.M = 48'd2; sb3.push_back(48'd2);
    tick();
    chk("stl_e2_occ", 64'(if3.OCC), 64'd2);
    if3.CEM = 1'b0; if3.M = 48'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stl_hold_occ", 64'(if3.OCC), 64'd2);
      chk("stl_hold_vld", 64'(if3.M_mux_vld), 64'd0);
      chk("stl_hold_mux", 64'(if3.M_mux), 64'd0);
    end
    if3.CEM = 1'b1; sb3.push_back(48'd3);
    for (int e = 7; e <= 10; e++) begin
      tick();
      if3.M_VLD = 1'b0; if3.M = 48'h7777;
      exp_vld = (e <= 9);
      exp_occ = (e == 7) ? 3 : 10 - e;
      chk("stl_vld", 64'(if3.M_mux_vld), 64'(exp_vld));
      chk("stl_occ", 64'(if3.OCC), 64'(exp_occ));
      if (if3.M_mux_vld) begin
        if (sb3.size() > 0) chk("stl_data", 64'(if3.M_mux), 64'(sb3.pop_front()));
        else chk("stl_sb_empty", 64'(sb3.size()), 64'd1);
      end
    end
    chk("stl_sb_drained", 64'(sb3.size()), 64'd0);

    // Back-to-back, DEPTH=4: M=0..9 every cycle
    if4.CEM = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      if (n <= 10) begin
        if4.M = 48'(n - 1); if4.M_VLD = 1'b1; sb4.push_back(48'(n - 1));
      end else begin
        if4.M = 48'hABCD; if4.M_VLD = 1'b0;
      end
      tick();
      exp_occ = (n <= 4) ? n : ((n <= 10) ? 4 : 14 - n);
      exp_vld = (n >= 4) && (n <= 13);
      chk("b2b_occ", 64'(if4.OCC), 64'(exp_occ));
      chk("b2b_vld", 64'(if4.M_mux_vld), 64'(exp_vld));
      if (if4.M_mux_vld) begin
        if (sb4.size() > 0) chk("b2b_data", 64'(if4.M_mux), 64'(sb4.pop_front()));
        else chk("b2b_sb_empty", 64'(sb4.size()), 64'd1);
      end
    end
    chk("b2b_sb_drained", 64'(sb4.size()), 64'd0);
    chk("b2b_busy_end", 64'(if4.BUSY), 64'd0);

    // Bypass, DEPTH=0: combinational follow, reset and CEM have no effect
    for (int i = 0; i < 6; i++) begin
      exp_d = (i % 2 == 0) ? 48'hFFFF_FFFF_FFFF : 48'h0000_0000_0000;
      exp_vld = (i % 2 == 0);
      if0.M = exp_d; if0.M_VLD = exp_vld; if0.CEM = (i >= 3);
      rstm = (i == 4);
      #1;
      chk("byp_mux", 64'(if0.M_mux), 64'(exp_d));
      chk("byp_vld", 64'(if0.M_mux_vld), 64'(exp_vld));
      chk("byp_occ", 64'(if0.OCC), 64'd0);
      chk("byp_busy", 64'(if0.BUSY), 64'd0);
      tick();
    end
    rstm = 1'b0;

`ifdef MREG_PIPE_FLUSH_EN
    // Flush, DEPTH=3: two products loaded, third presented with FLUSHM
    tick();
    if3.CEM = 1'b1; if3.M = 48'h11; if3.M_VLD = 1'b1;
    tick();
    if3.M = 48'h22;
    tick();
    chk("fl_pre_occ", 64'(if3.OCC), 64'd2);
    if3.M = 48'h33; flush3 = 1'b1;
    tick();
    flush3 = 1'b0; if3.M_VLD = 1'b0;
    chk("fl_occ", 64'(if3.OCC), 64'd0);
    chk("fl_busy", 64'(if3.BUSY), 64'd0);
    chk("fl_vld", 64'(if3.M_mux_vld), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_after_vld", 64'(if3.M_mux_vld), 64'd0);
      chk("fl_after_occ", 64'(if3.OCC), 64'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
